// File: rtl/rram_pc_sequencer.sv
// Instruction fetch/dispatch sequencer: walks instruction memory from a start PC,
// pops write operands from the input buffer and hands row/column ops to the array driver.
module rram_pc_sequencer #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int ADDR_SIZE_IM     = 7,
    parameter int ARRAY_SIZE       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_PC_IM,
    input  logic [ADDR_SIZE_IM-1:0]     start_PC_IM_address,
    output logic                        im_rd_en,
    output logic [ADDR_SIZE_IM-1:0]     im_addr,
    input  logic [INSTRUCTION_SIZE-1:0] im_rdata,
    input  logic                        ib_empty,
    input  logic [ARRAY_SIZE-1:0]       ib_rdata,
    output logic                        ib_rd_en,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic [3:0]                  op_code,
    output logic [3:0]                  op_row,
    output logic [3:0]                  op_col,
    output logic [ARRAY_SIZE-1:0]       op_data,
    output logic                        busy,
    output logic                        halted,
    output logic                        error,
    output logic [15:0]                 issue_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [3:0] OPC_NOP     = 4'h0;
    localparam logic [3:0] OPC_WRITE   = 4'h1;
    localparam logic [3:0] OPC_READ    = 4'h2;
    localparam logic [3:0] OPC_COMPUTE = 4'h3;
    localparam logic [3:0] OPC_HALT    = 4'hF;

    state_t                  state_reg, state_next;
    logic [ADDR_SIZE_IM-1:0] pc_reg;
    logic [11:0]             ir_reg;
    logic [3:0]              op_code_reg, op_row_reg, op_col_reg;
    logic [ARRAY_SIZE-1:0]   op_data_reg;
    logic                    error_reg;
    logic [15:0]             issue_count_reg;

    logic [3:0] ir_opcode, ir_row, ir_col;
    assign ir_opcode = ir_reg[11:8];
    assign ir_row    = ir_reg[7:4];
    assign ir_col    = ir_reg[3:0];

    // Only opcode/row/col are kept; the low instruction bits carry nothing.
    logic unused_ir_bits;
    assign unused_ir_bits = ^im_rdata[INSTRUCTION_SIZE-13:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        im_rd_en   = 1'b0;
        ib_rd_en   = 1'b0;
        case (state_reg)
            S_IDLE:  if (enable_PC_IM) state_next = S_FETCH;
            S_FETCH: begin
                if (enable_PC_IM) begin
                    im_rd_en   = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT:  state_next = S_DECODE;
            S_DECODE: begin
                case (ir_opcode)
                    OPC_NOP:                  state_next = S_FETCH;
                    OPC_READ, OPC_COMPUTE:    state_next = S_ISSUE;
                    OPC_WRITE: begin
                        // Stall here until an operand is available at the buffer head.
                        if (!ib_empty) begin
                            ib_rd_en   = 1'b1;
                            state_next = S_ISSUE;
                        end
                    end
                    default:                  state_next = S_HALT;
                endcase
            end
            S_ISSUE: if (op_ready) state_next = S_FETCH;
            S_HALT:  if (!enable_PC_IM) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= '0;
            ir_reg          <= '0;
            op_code_reg     <= '0;
            op_row_reg      <= '0;
            op_col_reg      <= '0;
            op_data_reg     <= '0;
            error_reg       <= 1'b0;
            issue_count_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (enable_PC_IM) pc_reg <= start_PC_IM_address;
                S_WAIT: ir_reg <= im_rdata[INSTRUCTION_SIZE-1 -: 12];
                S_DECODE: begin
                    case (ir_opcode)
                        OPC_NOP: pc_reg <= pc_reg + 1'b1;
                        OPC_READ, OPC_COMPUTE: begin
                            op_code_reg <= ir_opcode;
                            op_row_reg  <= ir_row;
                            op_col_reg  <= ir_col;
                        end
                        OPC_WRITE: begin
                            if (!ib_empty) begin
                                op_code_reg <= ir_opcode;
                                op_row_reg  <= ir_row;
                                op_col_reg  <= ir_col;
                                op_data_reg <= ib_rdata;
                            end
                        end
                        OPC_HALT: ;
                        default: error_reg <= 1'b1;
                    endcase
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        pc_reg <= pc_reg + 1'b1;
                        if (issue_count_reg != 16'hFFFF)
                            issue_count_reg <= issue_count_reg + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign im_addr     = pc_reg;
    assign op_valid    = (state_reg == S_ISSUE);
    assign op_code     = op_code_reg;
    assign op_row      = op_row_reg;
    assign op_col      = op_col_reg;
    assign op_data     = op_data_reg;
    assign busy        = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign halted      = (state_reg == S_HALT);
    assign error       = error_reg;
    assign issue_count = issue_count_reg;

endmodule
